// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snake_pkg
// Brief    : Shared state/direction encodings, scan codes and helpers for
//            the snake game core.
// Revision : 1.0 - initial release
// ============================================================================
package snake_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_WIN   = 3'd2,
        S_LOSE  = 3'd3,
        S_PAUSE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam logic [7:0] c_key_up      = 8'h43;
    localparam logic [7:0] c_key_down    = 8'h42;
    localparam logic [7:0] c_key_left    = 8'h3B;
    localparam logic [7:0] c_key_right   = 8'h4B;
    localparam logic [7:0] c_key_restart = 8'h4D;
    localparam logic [7:0] c_key_pause   = 8'h29;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

    function automatic logic is_dir_code(input logic [7:0] code);
        return (code == c_key_up) || (code == c_key_down) ||
               (code == c_key_left) || (code == c_key_right);
    endfunction

    function automatic dir_t decode_dir(input logic [7:0] code);
        case (code)
            c_key_up:   return DIR_UP;
            c_key_down: return DIR_DOWN;
            c_key_left: return DIR_LEFT;
            default:    return DIR_RIGHT;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/snake_dir_filter.sv
`default_nettype none
// ============================================================================
// Module   : snake_dir_filter
// Brief    : Decodes direction scan codes into the pending-direction register,
//            dropping 180-degree reversals outside IDLE.
// Revision : 1.0 - initial release
// ============================================================================
module snake_dir_filter
    import snake_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] key_code,
    input  logic       key_valid,
    input  logic [1:0] dir_cur,
    input  logic [2:0] state,
    output logic [1:0] dir_pend
);

    dir_t r_dir_pend;
    dir_t w_dir;
    logic w_valid;
    logic w_accept;

    assign w_dir   = decode_dir(key_code);
    assign w_valid = key_valid && is_dir_code(key_code);

    // dir_cur is the value the current direction will hold after this edge,
    // so a key arriving with a tick is judged against the new heading.
    always_comb begin
        w_accept = 1'b0;
        case (state_t'(state))
            S_IDLE:  w_accept = w_valid;
            S_PLAY:  w_accept = w_valid && (w_dir != opposite(dir_t'(dir_cur)));
            default: w_accept = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dir_pend <= DIR_LEFT;
        end else if (w_accept) begin
            r_dir_pend <= w_dir;
        end
    end

    assign dir_pend = r_dir_pend;

endmodule
`default_nettype wire

// File: rtl/snake_game_core.sv
`default_nettype none
// ============================================================================
// Module   : snake_game_core
// Brief    : Game FSM, tick-gated head stepping, border/food checks, score and
//            win/lose flags. Define SNAKE_PAUSE_EN to enable the PAUSE state.
// Revision : 1.0 - initial release
// ============================================================================
module snake_game_core
    import snake_pkg::*;
#(
    parameter int COORD_W   = 11,
    parameter int SCORE_W   = 4,
    parameter int STEP      = 10,
    parameter int X_MIN     = 220,
    parameter int X_MAX     = 700,
    parameter int Y_MIN     = 210,
    parameter int Y_MAX     = 460,
    parameter int START_X   = 470,
    parameter int START_Y   = 300,
    parameter int WIN_SCORE = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         key_code,
    input  logic               key_valid,
    input  logic               tick,
    input  logic [COORD_W-1:0] food_x,
    input  logic [COORD_W-1:0] food_y,
    output logic [COORD_W-1:0] head_x,
    output logic [COORD_W-1:0] head_y,
    output logic [SCORE_W-1:0] score,
    output logic               food_eaten,
    output logic               lfsr_reset,
    output logic               you_win,
    output logic               you_lose,
    output logic [2:0]         state_o
);

    localparam logic [COORD_W:0]   c_step      = (COORD_W+1)'(STEP);
    localparam logic [COORD_W:0]   c_x_min     = (COORD_W+1)'(X_MIN);
    localparam logic [COORD_W:0]   c_x_max     = (COORD_W+1)'(X_MAX);
    localparam logic [COORD_W:0]   c_y_min     = (COORD_W+1)'(Y_MIN);
    localparam logic [COORD_W:0]   c_y_max     = (COORD_W+1)'(Y_MAX);
    localparam logic [COORD_W-1:0] c_start_x   = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] c_start_y   = COORD_W'(START_Y);
    localparam logic [SCORE_W-1:0] c_win_score = SCORE_W'(WIN_SCORE);

    state_t             r_state, w_state_next;
    dir_t               r_dir_cur, w_dir_cur_next;
    logic [1:0]         w_dir_pend;
    logic [COORD_W-1:0] r_head_x, r_head_y, w_head_x_next, w_head_y_next;
    logic [COORD_W:0]   w_nx, w_ny;
    logic [SCORE_W-1:0] r_score, w_score_next, w_score_inc;
    logic               r_eat_lock, w_eat_lock_next, w_eat;
    logic               r_food_eaten, r_lfsr_reset, r_you_win, r_you_lose;
    logic               w_out, w_restart, w_key_dir;
`ifdef SNAKE_PAUSE_EN
    logic               w_pause;
    assign w_pause = key_valid && (key_code == c_key_pause);
`endif

    snake_dir_filter u_dir_filter (
        .clk       (clk),
        .reset     (reset),
        .key_code  (key_code),
        .key_valid (key_valid),
        .dir_cur   (w_dir_cur_next),
        .state     (r_state),
        .dir_pend  (w_dir_pend)
    );

    assign w_restart   = key_valid && (key_code == c_key_restart);
    assign w_key_dir   = key_valid && is_dir_code(key_code);
    assign w_score_inc = r_score + SCORE_W'(1);

    // One extra bit so a step below zero wraps high and fails the border test.
    always_comb begin
        w_nx = {1'b0, r_head_x};
        w_ny = {1'b0, r_head_y};
        case (dir_t'(w_dir_pend))
            DIR_UP:    w_ny = {1'b0, r_head_y} - c_step;
            DIR_DOWN:  w_ny = {1'b0, r_head_y} + c_step;
            DIR_LEFT:  w_nx = {1'b0, r_head_x} - c_step;
            default:   w_nx = {1'b0, r_head_x} + c_step;
        endcase
        w_out = (w_nx < c_x_min) || (w_nx > c_x_max) ||
                (w_ny < c_y_min) || (w_ny > c_y_max);
    end

    always_comb begin
        w_state_next    = r_state;
        w_head_x_next   = r_head_x;
        w_head_y_next   = r_head_y;
        w_score_next    = r_score;
        w_dir_cur_next  = r_dir_cur;
        w_eat_lock_next = r_eat_lock;
        w_eat           = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_head_x_next   = c_start_x;
                w_head_y_next   = c_start_y;
                w_score_next    = '0;
                w_dir_cur_next  = DIR_LEFT;
                w_eat_lock_next = 1'b0;
                if (w_key_dir) w_state_next = S_PLAY;
            end
            S_PLAY: begin
                if (w_restart) begin
                    w_state_next = S_IDLE;
`ifdef SNAKE_PAUSE_EN
                end else if (w_pause) begin
                    w_state_next = S_PAUSE;
`endif
                end else begin
                    if ((r_head_x == food_x) && (r_head_y == food_y) && !r_eat_lock) begin
                        w_eat           = 1'b1;
                        w_score_next    = w_score_inc;
                        w_eat_lock_next = 1'b1;
                        if (w_score_inc == c_win_score) w_state_next = S_WIN;
                    end
                    // Reaching WIN freezes the head even if a tick coincides.
                    if (tick && (w_state_next == S_PLAY)) begin
                        if (w_out) begin
                            w_state_next = S_LOSE;
                        end else begin
                            w_head_x_next   = w_nx[COORD_W-1:0];
                            w_head_y_next   = w_ny[COORD_W-1:0];
                            w_dir_cur_next  = dir_t'(w_dir_pend);
                            w_eat_lock_next = 1'b0;
                        end
                    end
                end
            end
`ifdef SNAKE_PAUSE_EN
            S_PAUSE: begin
                if (w_restart)    w_state_next = S_IDLE;
                else if (w_pause) w_state_next = S_PLAY;
            end
`endif
            S_WIN, S_LOSE: begin
                if (w_restart) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        if ((w_state_next == S_IDLE) && (r_state != S_IDLE)) begin
            w_head_x_next = c_start_x;
            w_head_y_next = c_start_y;
            w_score_next  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_head_x     <= c_start_x;
            r_head_y     <= c_start_y;
            r_score      <= '0;
            r_dir_cur    <= DIR_LEFT;
            r_eat_lock   <= 1'b0;
            r_food_eaten <= 1'b0;
            r_lfsr_reset <= 1'b1;
            r_you_win    <= 1'b0;
            r_you_lose   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_head_x     <= w_head_x_next;
            r_head_y     <= w_head_y_next;
            r_score      <= w_score_next;
            r_dir_cur    <= w_dir_cur_next;
            r_eat_lock   <= w_eat_lock_next;
            r_food_eaten <= w_eat;
            r_lfsr_reset <= (w_state_next == S_IDLE);
            r_you_win    <= (w_state_next == S_WIN);
            r_you_lose   <= (w_state_next == S_LOSE);
        end
    end

    assign head_x     = r_head_x;
    assign head_y     = r_head_y;
    assign score      = r_score;
    assign food_eaten = r_food_eaten;
    assign lfsr_reset = r_lfsr_reset;
    assign you_win    = r_you_win;
    assign you_lose   = r_you_lose;
    assign state_o    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_snake_game_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_game_core
// Brief    : Directed self-checking bench for snake_game_core (WIN_SCORE=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_game_core;

    logic        clk;
    logic        reset;
    logic [7:0]  key_code;
    logic        key_valid;
    logic        tick;
    logic [10:0] food_x, food_y;
    logic [10:0] head_x, head_y;
    logic [3:0]  score;
    logic        food_eaten, lfsr_reset, you_win, you_lose;
    logic [2:0]  state_o;

    int checks = 0;
    int errors = 0;

    snake_game_core #(.WIN_SCORE(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .tick       (tick),
        .food_x     (food_x),
        .food_y     (food_y),
        .head_x     (head_x),
        .head_y     (head_y),
        .score      (score),
        .food_eaten (food_eaten),
        .lfsr_reset (lfsr_reset),
        .you_win    (you_win),
        .you_lose   (you_lose),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] code);
        key_code  = code;
        key_valid = 1'b1;
        cyc();
        key_valid = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    initial begin
        reset = 1'b1; key_code = 8'h00; key_valid = 1'b0; tick = 1'b0;
        food_x = 11'd0; food_y = 11'd0;
        cyc(); cyc();
        reset = 1'b0;

        check("rst_state", state_o, 0);
        check("rst_hx", head_x, 470);
        check("rst_hy", head_y, 300);
        check("rst_score", score, 0);
        check("rst_lfsr", lfsr_reset, 1);
        check("rst_flags", {food_eaten, you_win, you_lose}, 0);

        press(8'h3B);
        check("idle_to_play", state_o, 1);
        check("play_lfsr", lfsr_reset, 0);
        check("play_hx0", head_x, 470);
        for (int i = 1; i <= 10; i++) begin
            do_tick();
            check("left_walk", head_x, 470 - 10 * i);
        end
        check("left_hy", head_y, 300);
        check("left_score", score, 0);

        press(8'h4B);
        do_tick();
        check("reversal_dropped", head_x, 360);
        press(8'h43);
        do_tick();
        check("up_hy", head_y, 290);
        check("up_hx", head_x, 360);

        press(8'h3B);
        for (int i = 0; i < 14; i++) do_tick();
        check("at_border", head_x, 220);
        check("at_border_state", state_o, 1);
        do_tick();
        check("lose_state", state_o, 3);
        check("lose_flag", you_lose, 1);
        check("lose_hx", head_x, 220);
        do_tick();
        press(8'h43);
        check("lose_frozen_x", head_x, 220);
        check("lose_frozen_y", head_y, 290);
        press(8'h4D);
        check("restart_state", state_o, 0);
        check("restart_hx", head_x, 470);
        check("restart_hy", head_y, 300);
        check("restart_flag", you_lose, 0);
        check("restart_lfsr", lfsr_reset, 1);

        food_x = 11'd460; food_y = 11'd300;
        press(8'h3B);
        do_tick();
        check("eat_hx", head_x, 460);
        check("eat_latency", food_eaten, 0);
        cyc();
        check("eat_pulse", food_eaten, 1);
        check("eat_score", score, 1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("eat_no_repeat", food_eaten, 0);
        end
        check("eat_score_hold", score, 1);

        food_x = 11'd450;
        do_tick();
        check("win_pre_hx", head_x, 450);
        cyc();
        check("win_pulse", food_eaten, 1);
        check("win_score", score, 2);
        check("win_state", state_o, 2);
        check("win_flag", you_win, 1);
        do_tick();
        press(8'h43);
        do_tick();
        check("win_frozen_x", head_x, 450);
        check("win_frozen_y", head_y, 300);
        check("win_score_sat", score, 2);
        press(8'h4D);
        check("win_restart_state", state_o, 0);
        check("win_restart_score", score, 0);
        check("win_restart_flag", you_win, 0);

        food_x = 11'd0; food_y = 11'd0;
        press(8'h3B);
        do_tick();
        check("pre_reset_hx", head_x, 460);
        reset = 1'b1; tick = 1'b1; key_code = 8'h43; key_valid = 1'b1;
        cyc();
        reset = 1'b0; tick = 1'b0; key_valid = 1'b0;
        check("midrst_state", state_o, 0);
        check("midrst_hx", head_x, 470);
        check("midrst_hy", head_y, 300);
        check("midrst_score", score, 0);
        check("midrst_lfsr", lfsr_reset, 1);
        check("midrst_flags", {food_eaten, you_win, you_lose}, 0);

        // DOWN arrives with the tick that commits UP, so it must be dropped.
        press(8'h3B);
        do_tick();
        press(8'h43);
        key_code = 8'h42; key_valid = 1'b1; tick = 1'b1;
        cyc();
        key_valid = 1'b0; tick = 1'b0;
        check("same_cyc_hx", head_x, 460);
        check("same_cyc_hy", head_y, 290);
        do_tick();
        check("same_cyc_reject", head_y, 280);

`ifdef SNAKE_PAUSE_EN
        press(8'h29);
        check("pause_state", state_o, 4);
        do_tick();
        do_tick();
        check("pause_hold", head_y, 280);
        press(8'h29);
        check("resume_state", state_o, 1);
        do_tick();
        check("resume_move", head_y, 270);
`else
        press(8'h29);
        check("pause_ignored", state_o, 1);
        do_tick();
        check("pause_key_move", head_y, 270);
`endif

        press(8'h4D);
        check("play_restart_state", state_o, 0);
        check("play_restart_hy", head_y, 300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
